// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Op encoding follows the funct3 field of the M-extension instructions.
package muldiv_pkg;

    localparam int XLEN = 32;

    // Iteration counter must be able to hold the value XLEN (final fix-up step).
    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

endpackage

// File: rtl/muldiv_seq_div_step.sv
// One combinational restoring-divide step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep the difference when
// it does not go negative. The partial remainder is always below the divisor,
// so one guard bit is enough to detect the borrow.
module div_step
    import muldiv_pkg::*;
#(
    parameter int DWIDTH = XLEN
) (
    input  logic [DWIDTH-1:0] rem_in,
    input  logic              dividend_bit,
    input  logic [DWIDTH-1:0] divisor,
    output logic [DWIDTH-1:0] rem_out,
    output logic              q_bit
);

    logic [DWIDTH:0] shifted;
    logic [DWIDTH:0] diff;

    assign shifted = {rem_in, dividend_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[DWIDTH];
    assign rem_out = q_bit ? diff[DWIDTH-1:0] : shifted[DWIDTH-1:0];

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer.
// Multiplies finish after one registered cycle; divides and remainders run
// a radix-2 restoring divider (one quotient bit per cycle, MSB first) followed
// by one sign fix-up cycle. Divide-by-zero and signed overflow are resolved
// at accept time.
// Build option: define MULDIV_EARLY_OUT_EN to finish divides whose dividend
// magnitude is below the divisor magnitude directly at accept.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int DWIDTH = XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_sel,
    input  logic [DWIDTH-1:0] req_a,
    input  logic [DWIDTH-1:0] req_b,
    input  logic              kill,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              busy
);

    localparam int CW = (DWIDTH == XLEN) ? CNT_W : $clog2(DWIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DWIDTH);

    state_e state, state_nx;

    // Latched request
    logic [DWIDTH-1:0] a_reg;
    logic [DWIDTH-1:0] b_reg;
    logic [2:0]        sel_reg;

    // Divider working registers
    logic [DWIDTH-1:0] rem_reg;
    logic [DWIDTH-1:0] quo_reg;   // dividend shifts out of the top, quotient in at the bottom
    logic [DWIDTH-1:0] dvsr_reg;
    logic              neg_q;
    logic              neg_r;
    logic [CW-1:0]     cnt;

    logic [DWIDTH-1:0] result;

    // Accept-time decode
    logic              accept;
    logic              req_signed;
    logic              req_is_rem;
    logic              a_neg;
    logic              b_neg;
    logic [DWIDTH-1:0] a_mag;
    logic [DWIDTH-1:0] b_mag;
    logic              b_zero;
    logic              ovf;
    logic              special;
    logic [DWIDTH-1:0] special_res;
    logic              early;
    logic [DWIDTH-1:0] early_res;

    assign accept     = req_valid & req_ready & ~kill;
    assign req_signed = ~req_sel[0];
    assign req_is_rem = req_sel[1];
    assign a_neg      = req_signed & req_a[DWIDTH-1];
    assign b_neg      = req_signed & req_b[DWIDTH-1];
    assign a_mag      = a_neg ? (~req_a + 1'b1) : req_a;
    assign b_mag      = b_neg ? (~req_b + 1'b1) : req_b;
    assign b_zero     = (req_b == '0);
    assign ovf        = req_signed && (req_a == {1'b1, {(DWIDTH-1){1'b0}}}) && (&req_b);
    assign special    = req_sel[2] & (b_zero | ovf);

    // Divide by zero: quotient all ones, remainder = dividend.
    // Signed overflow: quotient = dividend (most negative value), remainder 0.
    assign special_res = b_zero ? (req_is_rem ? req_a : '1)
                                : (req_is_rem ? '0    : req_a);

`ifdef MULDIV_EARLY_OUT_EN
    assign early = req_sel[2] & ~b_zero & (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif
    assign early_res = req_is_rem ? req_a : '0;

    // Multiplier: both operands extended to full product width with the
    // signedness the op requires, so the low 2*DWIDTH bits are exact.
    logic                       a_sgn_mul;
    logic                       b_sgn_mul;
    logic signed [2*DWIDTH-1:0] a_ext;
    logic signed [2*DWIDTH-1:0] b_ext;
    logic signed [2*DWIDTH-1:0] prod;
    logic [DWIDTH-1:0]          mul_res;

    assign a_sgn_mul = (sel_reg != OP_MULHU);
    assign b_sgn_mul = (sel_reg == OP_MUL) || (sel_reg == OP_MULH);
    assign a_ext     = {{DWIDTH{a_sgn_mul & a_reg[DWIDTH-1]}}, a_reg};
    assign b_ext     = {{DWIDTH{b_sgn_mul & b_reg[DWIDTH-1]}}, b_reg};
    assign prod      = a_ext * b_ext;
    assign mul_res   = (sel_reg == OP_MUL) ? prod[DWIDTH-1:0] : prod[2*DWIDTH-1:DWIDTH];

    // Divider step and final sign correction
    logic [DWIDTH-1:0] step_rem;
    logic              step_q;
    logic [DWIDTH-1:0] div_res;

    div_step #(.DWIDTH(DWIDTH)) u_div_step (
        .rem_in       (rem_reg),
        .dividend_bit (quo_reg[DWIDTH-1]),
        .divisor      (dvsr_reg),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    assign div_res = sel_reg[1] ? (neg_r ? (~rem_reg + 1'b1) : rem_reg)
                                : (neg_q ? (~quo_reg + 1'b1) : quo_reg);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; kill overrides every other transition
    always_comb begin
        state_nx = state;
        if (kill) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (!req_sel[2])            state_nx = S_MUL;
                        else if (special || early)  state_nx = S_DONE;
                        else                        state_nx = S_DIV;
                    end
                end
                S_MUL:  state_nx = S_DONE;
                S_DIV:  if (cnt == LAST) state_nx = S_DONE;
                S_DONE: if (rsp_ready) state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Datapath: latch on accept, produce the multiply result, iterate the divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sel_reg  <= '0;
            rem_reg  <= '0;
            quo_reg  <= '0;
            dvsr_reg <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
        end else if (!kill) begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_reg    <= req_a;
                        b_reg    <= req_b;
                        sel_reg  <= req_sel;
                        rem_reg  <= '0;
                        quo_reg  <= a_mag;
                        dvsr_reg <= b_mag;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        cnt      <= '0;
                        if (special)    result <= special_res;
                        else if (early) result <= early_res;
                    end
                end
                S_MUL: result <= mul_res;
                S_DIV: begin
                    if (cnt == LAST) begin
                        result <= div_res;
                    end else begin
                        rem_reg <= step_rem;
                        quo_reg <= {quo_reg[DWIDTH-2:0], step_q};
                        cnt     <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign rsp_data  = rsp_valid ? result : '0;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: expected results and latencies are
// queued when an op is issued and compared when the response appears.
module tb_muldiv_seq;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_sel;
    logic [DW-1:0] req_a;
    logic [DW-1:0] req_b;
    logic          kill;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    always #5 clk = ~clk;

    muldiv_seq #(.DWIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_a     (req_a),
        .req_b     (req_b),
        .kill      (kill),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Reference model built on the simulator's own signed/unsigned arithmetic.
    function automatic logic [31:0] model(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        int signed ia, ib;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (sel)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges from the accept edge (inclusive) to the first cycle with rsp_valid.
    function automatic int model_lat(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ma, mb;
        logic sgn;
        if (!sel[2]) return 2;
        if (b == 0) return 1;
        if (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        sgn = ~sel[0];
        ma  = (sgn && a[31]) ? -$signed({{32{1'b1}}, a}) : $signed({32'd0, a});
        mb  = (sgn && b[31]) ? -$signed({{32{1'b1}}, b}) : $signed({32'd0, b});
`ifdef MULDIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`else
        if (ma < mb) return DW + 2;
`endif
        return DW + 2;
    endfunction

    // Issue one op, wait (bounded) for its response, compare data and latency.
    task automatic run_op(input string name, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [31:0] e;
        int el;
        exp_q.push_back(model(sel, a, b));
        lat_q.push_back(model_lat(sel, a, b));
        @(negedge clk);
        check({name, "_rdy"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_sel   = sel;
        req_a     = a;
        req_b     = b;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        if (!rsp_valid) begin
            check({name, "_timeout"}, 64'(rsp_valid), 64'd1);
        end else begin
            check({name, "_data"}, 64'(rsp_data), 64'(e));
            check({name, "_lat"}, 64'(lat), 64'(el));
            @(posedge clk);
            #1;
            check({name, "_vld_drop"}, 64'(rsp_valid), 64'd0);
        end
    endtask

    initial begin
        logic [31:0] e;
        int lat;
        int seen;
        logic [2:0] rs;
        logic [31:0] ra, rb;

        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_sel   = '0;
        req_a     = '0;
        req_b     = '0;
        kill      = 1'b0;
        rsp_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        run_op("mulh_m1x2", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op("mul_m1x2", 3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_by0", 3'd5, 32'd100, 32'd0);
        run_op("rem_by0", 3'd6, 32'h1234_5678, 32'd0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mulhsu_neg", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("remu_3_10", 3'd7, 32'd3, 32'd10);
        run_op("rem_neg_small", 3'd6, 32'hFFFF_FFF9, 32'd8);
        run_op("divu_max", 3'd5, 32'hFFFF_FFFF, 32'd1);

        // Backpressure: result held stable while the consumer stalls
        exp_q.push_back(model(3'd5, 32'd1000, 32'd7));
        @(negedge clk);
        req_valid = 1'b1; req_sel = 3'd5; req_a = 32'd1000; req_b = 32'd7;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_lat", 64'(lat), 64'(DW + 2));
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            check("bp_data", 64'(rsp_data), 64'(e));
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        check("bp_hs_data", 64'(rsp_data), 64'(e));
        check("bp_hs_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        check("bp_after_req_ready", 64'(req_ready), 64'd1);
        check("bp_after_valid", 64'(rsp_valid), 64'd0);

        // Kill during iteration 10 of a DIVU
        @(negedge clk);
        req_valid = 1'b1; req_sel = 3'd5; req_a = 32'd1000; req_b = 32'd7;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_busy", 64'(busy), 64'd0);
        check("kill_req_ready", 64'(req_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        check("kill_no_rsp", 64'(seen), 64'd0);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Request offered together with kill is ignored
        @(negedge clk);
        req_valid = 1'b1; req_sel = 3'd0; req_a = 32'd3; req_b = 32'd4;
        kill = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        kill = 1'b0;
        check("kill_req_not_taken", 64'(busy), 64'd0);

        // Kill while a result is pending drops it
        @(negedge clk);
        req_valid = 1'b1; req_sel = 3'd5; req_a = 32'd100; req_b = 32'd0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("kdone_valid", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kdone_dropped", 64'(rsp_valid), 64'd0);
        check("kdone_idle", 64'(req_ready), 64'd1);
        rsp_ready = 1'b1;

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        req_valid = 1'b1; req_sel = 3'd4; req_a = 32'd12345; req_b = 32'd17;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("arst_pre_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", 64'(req_ready), 64'd1);
        check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("arst_rsp_data", 64'(rsp_data), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        check("arst_no_rsp", 64'(seen), 64'd0);
        run_op("remu_post_rst", 3'd7, 32'd3, 32'd10);

        // Mixed random operations
        for (int i = 0; i < 20; i++) begin
            rs = 3'($urandom_range(0, 7));
            ra = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) ra = -ra;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = 32'($urandom_range(0, 20));
                2: rb = -32'($urandom_range(1, 20));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op("rand", rs, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Sequencing controller for the RV32M execution path.
- Accepts one M-extension operation at a time over a valid/ready handshake.
- Multiplies complete in one registered cycle; divides and remainders run on an internal radix-2 restoring divider iterated over DWIDTH cycles.
- Sits between the decode/issue stage and writeback, and stalls issue while busy.

Parameters:
- DWIDTH, 32, operand and result width (RV32 = 32).

Ports:
- Clk  input  1  system clock
- Rst_N  input  1  asynchronous active-low reset
- Req_Valid  input  1  operation offered
- Req_Ready  output  1  block can accept an operation
- Req_Sel  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- Req_A  input  DWIDTH  rs1 operand
- Req_B  input  DWIDTH  rs2 operand
- Kill  input  1  flush; abandons any in-flight operation
- Rsp_Valid  output  1  result available
- Rsp_Ready  input  1  consumer takes result
- Rsp_Data  output  DWIDTH  selected result
- Busy  output  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE, Req_Ready=1, Rsp_Valid=0, Rsp_Data=0, Busy=0; all datapath registers cleared. Reset mid-operation discards the operation with no response.
- Accept occurs when Req_Valid && Req_Ready at a rising edge; operands and Sel are latched. Req_Ready=1 only in IDLE.
- States: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL on accepting Sel[2]=0.
  - IDLE -> DIV on accepting Sel[2]=1 with a non-special divide.
  - IDLE -> DONE on accepting a special-case divide.
  - MUL -> DONE after 1 cycle.
  - DIV -> DONE after DWIDTH iterations.
  - DONE -> IDLE when Rsp_Ready.
- Rsp_Valid=1 only in DONE. Rsp_Data is stable while Rsp_Valid && !Rsp_Ready.
- Latency from accept edge to first Rsp_Valid cycle:
  - MUL*: 2 cycles.
  - Special divide: 1 cycle.
  - Normal divide: DWIDTH+2 cycles.
- Multiply: 2*DWIDTH product with operand signedness MUL/MULH = s×s, MULHSU = s×u, MULHU = u×u. MUL returns product[DWIDTH-1:0]; the others return product[2*DWIDTH-1:DWIDTH].
- Divide: operands converted to magnitudes for signed ops. Unsigned restoring divide, 1 quotient bit per cycle, MSB first.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
  - Truncation toward zero.
- Special cases, resolved at accept:
  - B=0: DIV/DIVU -> all ones; REM/REMU -> A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Kill has priority over every other event: state -> IDLE next cycle, Rsp_Valid deasserts. A request presented in the same cycle as Kill is not accepted.
- Kill while in DONE drops the pending result.
- No back-to-back accept in the cycle DONE exits; Req_Ready rises the cycle after.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: an unsigned or magnitude dividend strictly less than the divisor magnitude (divisor non-zero) goes IDLE -> DONE with quotient 0 and remainder equal to the signed dividend; latency 1 cycle.
- Undefined: such operations take the full DWIDTH+2 latency with identical results.

Decomposition:
- Package muldiv_pkg holds:
  - the 3-bit op enum (MUL..REMU) shared with the combinational multiplier and decoder;
  - the state enum (IDLE, MUL, DIV, DONE);
  - the iteration counter width localparam $clog2(DWIDTH+1).
- Sub-module div_step: one combinational restoring-divide step (partial remainder, divisor -> next remainder, quotient bit). muldiv_seq instantiates it once and registers its result each DIV cycle.

Test Plan:
- MULH A=0xFFFFFFFF, B=0x00000002, Rsp_Ready=1 -> Rsp_Valid 2 cycles after accept, Rsp_Data=0xFFFFFFFF; MUL with the same operands -> 0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Rsp_Data=0xFFFFFFFD after 34 cycles; REM with the same operands -> 0xFFFFFFFF.
- DIVU A=100, B=0 -> 0xFFFFFFFF after 1 cycle; REM A=0x80000000, B=0xFFFFFFFF -> 0; DIV with the same operands -> 0x80000000.
- DIVU A=1000, B=7 with Rsp_Ready held low 5 cycles after Rsp_Valid -> Rsp_Data=142 stable throughout, Req_Ready=0 until the cycle after the handshake.
- Kill asserted on iteration 10 of DIVU -> IDLE next cycle, no Rsp_Valid. A subsequent MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- Rst_N pulsed low mid-DIV -> all outputs at reset values asynchronously. With MULDIV_EARLY_OUT_EN defined, REMU A=3, B=10 -> 3 after 1 cycle; without it, after 34 cycles.
